seg_scan_driver: RTL

- Time-multiplexed N-digit 7-segment display driver. Next generation of the microwave's 3-digit combinational BCD decoder.
- Latches a packed BCD word on a strobe, scans one digit at a time through shared segment lines, and drives per-digit anodes.
- Adds three display features: leading-zero blanking, a blink mode (e.g. "cook done" or "set time") and inter-digit dead time against ghosting.
- Sits between the timer/controller and the board's multiplexed display pins.

---
 rtl/seg_pkg.sv | 44 ++++
 rtl/seg_prescaler.sv | 63 ++++++
 rtl/seg_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and the nibble-to-segment decoder for the
// multiplexed 7-segment display driver.
//
// Contents:
//   SEG_BLANK     - all segments off (active-low), 7'h7F
//   SEG_PATTERNS  - 16-entry active-low pattern table, bit order g..a
//   seg_decode()  - nibble -> active-low segment pattern
//
// Configuration macro: SEG_HEX_EN
//   defined   - nibbles 10..15 display A, b, C, d, E, F
//   undefined - nibbles 10..15 display blank
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 15 is listed first so SEG_PATTERNS[n] is the pattern for nibble n.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
`ifdef SEG_HEX_EN
    return SEG_PATTERNS[nibble];
`else
    return (nibble > 4'd9) ? SEG_BLANK : SEG_PATTERNS[nibble];
`endif
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler: scan-slot timebase and blink timebase.
//
// Ports:
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   presc_o       - current position inside the digit slot, 0..SCAN_DIV-1
//   tick_o        - high in the last cycle of each slot
//   blink_phase_o - toggles every BLINK_DIV slots; 1 = display suppressed
//                   when blinking is enabled
module seg_prescaler #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 256,
  localparam int unsigned PW = $clog2(SCAN_DIV),
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [PW-1:0] presc_o,
  output logic          tick_o,
  output logic          blink_phase_o
);

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          blinkPhase_q, blinkPhase_d;
  logic          tick;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));

  // The blink counter keeps running while blinking is disabled, so enabling
  // it mid-stream joins an already established rhythm.
  always_comb begin
    presc_d      = presc_q + PW'(1);
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (tick) begin
      presc_d = '0;
      if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  assign presc_o       = presc_q;
  assign tick_o        = tick;
  assign blink_phase_o = blinkPhase_q;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit 7-segment display driver.
// Latches a packed BCD word on load, scans one digit per slot through the
// shared segment lines, with leading-zero blanking, whole-display blinking
// and a dead time at the start of each slot against ghosting.
//
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   digits_in   - packed BCD, nibble i = digit i, digit 0 least significant
//   load        - captures digits_in into the shadow register
//   blank_lead  - enable leading-zero blanking
//   blink_en    - enable blinking of the whole display
//   seg_n       - segments g..a, active-low
//   an_n        - digit enables, active-low, at most one low
//   frame_start - one-cycle pulse when outputs begin showing slot 0
//
// Configuration macro: SEG_HEX_EN (see seg_pkg) selects hex display of
// nibbles 10..15 instead of blank.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned BLINK_DIV   = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blank_lead,
  input  logic                    blink_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] DEAD_V = PW'(DEAD_CYCLES);

  logic [PW-1:0]           presc;
  logic                    tick;
  logic                    blinkPhase;

  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [IW-1:0]           digitIdx_q, digitIdx_d;
  logic [6:0]              segN_q, segN_d;
  logic [NUM_DIGITS-1:0]   anN_q, anN_d;
  logic                    frameStart_q, frameStart_d;

  logic [NUM_DIGITS-1:0]   leadBlank;
  logic                    allZero;
  logic [3:0]              curNibble;
  logic                    dark;

  seg_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .presc_o      (presc),
    .tick_o       (tick),
    .blink_phase_o(blinkPhase)
  );

  // Walk from the most significant digit down: a digit is a leading zero
  // while every digit at or above it is zero. Digit 0 always stays lit.
  always_comb begin
    allZero   = 1'b1;
    leadBlank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      allZero      = allZero && (shadow_q[4*k +: 4] == 4'd0);
      leadBlank[k] = blank_lead && allZero && (k != 0);
    end
  end

  assign curNibble = shadow_q[{digitIdx_q, 2'b00} +: 4];

  always_comb begin
    digitIdx_d = digitIdx_q;
    if (tick) begin
      digitIdx_d = (digitIdx_q == IW'(NUM_DIGITS - 1)) ? '0 : digitIdx_q + IW'(1);
    end
  end

  // Output stage sees the state of the current cycle and registers it, so
  // the pins lag the counters by one cycle and never glitch.
  always_comb begin
    dark         = (presc < DEAD_V) || (blink_en && blinkPhase) || leadBlank[digitIdx_q];
    anN_d        = dark ? '1 : ~(NUM_DIGITS'(1) << digitIdx_q);
    segN_d       = dark ? SEG_BLANK : seg_decode(curNibble);
    frameStart_d = (presc == '0) && (digitIdx_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      digitIdx_q   <= '0;
      segN_q       <= SEG_BLANK;
      anN_q        <= '1;
      frameStart_q <= 1'b0;
    end else begin
      if (load) begin
        shadow_q <= digits_in;
      end
      digitIdx_q   <= digitIdx_d;
      segN_q       <= segN_d;
      anN_q        <= anN_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign seg_n       = segN_q;
  assign an_n        = anN_q;
  assign frame_start = frameStart_q;

endmodule
